pipe_control: RTL and testbench
===============================

Name: pipe_control

Overview:
Parametrised, pipelined successor to the single-cycle opcode decoder. Decodes the ID-stage opcode into the 8-bit control word and carries its EX/M/WB fields through the ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards and inserts bubbles, generates IF flush on taken branch/jump, and supports a global hold. It sits between the ID stage and the pipeline datapath registers of the 5-stage MIPS core.

Parameters:
OP_W, 6, opcode width
REG_W, 5, register address width
ALUOP_W, 2, ALUOp field width; control word width CW = ALUOP_W + 6

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
Op_i  in  OP_W  opcode of instruction in ID
RsAddr_i  in  REG_W  rs of instruction in ID
RtAddr_i  in  REG_W  rt of instruction in ID
Eq_i  in  1  ID-stage register comparator result (rs==rt)
Hold_i  in  1  global freeze (external stall)
PCWrite_o  out  1  PC update enable
IFIDWrite_o  out  1  IF/ID register write enable
IFFlush_o  out  1  zero IF/ID on next edge
Branch_o  out  1  taken beq in ID, selects branch target
Jump_o  out  1  jump in ID, selects jump target
Ctrl_o  out  CW  raw ID decode (pre-bubble)
ExRt_o  out  REG_W  rt held in ID/EX
ALUSrc_o  out  1  from ID/EX
ALUOp_o  out  ALUOP_W  from ID/EX
RegDst_o  out  1  from ID/EX
MemRead_o  out  1  from EX/MEM
MemWrite_o  out  1  from EX/MEM
RegWrite_o  out  1  from MEM/WB
MemtoReg_o  out  1  from MEM/WB
IllegalOp_o  out  1  sticky: undefined opcode seen in ID

Behaviour:
- Control word bits: [0] ALUSrc, [ALUOP_W:1] ALUOp, then RegDst, MemRead, MemWrite, RegWrite, MemtoReg in ascending order.
- Decode is combinational; every don't-care is driven as 0.
  - R-type 000000: ALUOp=11, RegDst=1, RegWrite=1.
  - addi 001000: ALUSrc=1, RegWrite=1.
  - lw 100011: ALUSrc=1, MemRead=1, RegWrite=1, MemtoReg=1.
  - sw 101011: ALUSrc=1, MemWrite=1.
  - beq 000100: ALUOp=01.
  - j 000010: all zero, Jump.
  - Any other opcode: all zero (NOP) and IllegalOp_o set on the next edge unless Hold_i; it stays set until reset.
- Stage registers: ID/EX holds the full control word plus rt. EX/MEM holds M and WB fields. MEM/WB holds WB fields. All advance every edge unless Hold_i=1, in which case all hold.
- Load-use stall: stall = ID/EX.MemRead & (ExRt == RsAddr_i | ExRt == RtAddr_i) & ExRt != 0.
  - On stall: PCWrite_o=0, IFIDWrite_o=0, and a zero word is loaded into ID/EX. EX/MEM and MEM/WB advance normally.
  - Stall lasts exactly one cycle, because the bubble clears ID/EX.MemRead.
- Branch_o = (Op==beq) & Eq_i & ~stall. Jump_o = (Op==j) & ~stall. IFFlush_o = Branch_o | Jump_o.
- Priority: Hold_i over stall over branch/jump.
  - Hold_i=1 forces PCWrite_o=0, IFIDWrite_o=0, IFFlush_o=0, Branch_o=0, Jump_o=0.
- Otherwise PCWrite_o=1 and IFIDWrite_o=1.
- Reset (rst_i=0): all stage registers and IllegalOp_o clear to 0 immediately. PCWrite_o, IFIDWrite_o, IFFlush_o, Branch_o and Jump_o are forced to 0 while reset is asserted.
- After release, first edge behaves as a normal advance.
- Reset mid-stall discards the pending bubble. No state beyond the stage registers and the sticky flag.

Test Plan:
1. R-type add in ID, no hazard -> edge 1: ALUOp_o=11, RegDst_o=1. Edge 3: RegWrite_o=1, MemtoReg_o=0. PCWrite_o=1 throughout.
2. lw rt=8, then add with rs=8 in ID -> one cycle PCWrite_o=0, IFIDWrite_o=0; next edge ID/EX all zero. Second cycle PCWrite_o=1; add reaches EX one cycle late.
3. lw rt=0, then add rs=0 -> no stall, PCWrite_o=1.
4. beq with Eq_i=1 -> Branch_o=1, IFFlush_o=1 same cycle. With Eq_i=0 -> both 0. beq coinciding with a load-use stall -> Branch_o=0.
5. j in ID with Hold_i=1 -> Jump_o=0, stage outputs frozen. Drop Hold_i -> Jump_o=1, IFFlush_o=1.
6. Opcode 111111 -> Ctrl_o=0 and IllegalOp_o=1 after the edge, persisting. Assert rst_i=0 mid-pipeline -> all outputs 0 asynchronously, IllegalOp_o=0.

Source files
------------

// File: rtl/pipe_control.sv
`default_nettype none
// ============================================================================
// Module   : pipe_control
// Purpose  : ID-stage opcode decode, pipelined EX/M/WB control, load-use
//            bubble insertion, IF flush on taken branch/jump, global hold.
// Revision : 1.0
// ============================================================================
module pipe_control #(
  parameter int OP_W    = 6,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [OP_W-1:0]      Op_i,
  input  logic [REG_W-1:0]     RsAddr_i,
  input  logic [REG_W-1:0]     RtAddr_i,
  input  logic                 Eq_i,
  input  logic                 Hold_i,
  output logic                 PCWrite_o,
  output logic                 IFIDWrite_o,
  output logic                 IFFlush_o,
  output logic                 Branch_o,
  output logic                 Jump_o,
  output logic [ALUOP_W+5:0]   Ctrl_o,
  output logic [REG_W-1:0]     ExRt_o,
  output logic                 ALUSrc_o,
  output logic [ALUOP_W-1:0]   ALUOp_o,
  output logic                 RegDst_o,
  output logic                 MemRead_o,
  output logic                 MemWrite_o,
  output logic                 RegWrite_o,
  output logic                 MemtoReg_o,
  output logic                 IllegalOp_o
);

  localparam int c_cw         = ALUOP_W + 6;
  localparam int c_b_alusrc   = 0;
  localparam int c_b_regdst   = ALUOP_W + 1;
  localparam int c_b_memread  = ALUOP_W + 2;
  localparam int c_b_memwrite = ALUOP_W + 3;
  localparam int c_b_regwrite = ALUOP_W + 4;
  localparam int c_b_memtoreg = ALUOP_W + 5;

  localparam logic [OP_W-1:0] c_op_rtype = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] c_op_addi  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] c_op_lw    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] c_op_sw    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] c_op_beq   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] c_op_j     = OP_W'(6'b000010);

  logic [c_cw-1:0]  w_ctrl;
  logic             w_illegal_op;
  logic             w_is_beq;
  logic             w_is_j;
  logic             w_stall;
  logic             w_run;

  logic [c_cw-1:0]  r_idex_cw;
  logic [REG_W-1:0] r_idex_rt;
  logic             r_exmem_memread;
  logic             r_exmem_memwrite;
  logic             r_exmem_regwrite;
  logic             r_exmem_memtoreg;
  logic             r_memwb_regwrite;
  logic             r_memwb_memtoreg;
  logic             r_illegal;

  always_comb begin
    w_ctrl       = '0;
    w_illegal_op = 1'b0;
    w_is_beq     = 1'b0;
    w_is_j       = 1'b0;
    case (Op_i)
      c_op_rtype: begin
        w_ctrl[ALUOP_W:1]   = ALUOP_W'(3);
        w_ctrl[c_b_regdst]  = 1'b1;
        w_ctrl[c_b_regwrite] = 1'b1;
      end
      c_op_addi: begin
        w_ctrl[c_b_alusrc]   = 1'b1;
        w_ctrl[c_b_regwrite] = 1'b1;
      end
      c_op_lw: begin
        w_ctrl[c_b_alusrc]   = 1'b1;
        w_ctrl[c_b_memread]  = 1'b1;
        w_ctrl[c_b_regwrite] = 1'b1;
        w_ctrl[c_b_memtoreg] = 1'b1;
      end
      c_op_sw: begin
        w_ctrl[c_b_alusrc]   = 1'b1;
        w_ctrl[c_b_memwrite] = 1'b1;
      end
      c_op_beq: begin
        w_ctrl[ALUOP_W:1] = ALUOP_W'(1);
        w_is_beq          = 1'b1;
      end
      c_op_j:  w_is_j = 1'b1;
      default: w_illegal_op = 1'b1;
    endcase
  end

  // The bubble clears ID/EX MemRead, so a stall never lasts past one cycle.
  assign w_stall = r_idex_cw[c_b_memread] & (r_idex_rt != '0) &
                   ((r_idex_rt == RsAddr_i) | (r_idex_rt == RtAddr_i));
  assign w_run   = rst_i & ~Hold_i;

  assign PCWrite_o   = w_run & ~w_stall;
  assign IFIDWrite_o = w_run & ~w_stall;
  assign Branch_o    = w_run & w_is_beq & Eq_i & ~w_stall;
  assign Jump_o      = w_run & w_is_j & ~w_stall;
  assign IFFlush_o   = Branch_o | Jump_o;
  assign Ctrl_o      = w_ctrl;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_idex_cw        <= '0;
      r_idex_rt        <= '0;
      r_exmem_memread  <= 1'b0;
      r_exmem_memwrite <= 1'b0;
      r_exmem_regwrite <= 1'b0;
      r_exmem_memtoreg <= 1'b0;
      r_memwb_regwrite <= 1'b0;
      r_memwb_memtoreg <= 1'b0;
      r_illegal        <= 1'b0;
    end else if (!Hold_i) begin
      r_idex_cw        <= w_stall ? '0 : w_ctrl;
      r_idex_rt        <= w_stall ? '0 : RtAddr_i;
      r_exmem_memread  <= r_idex_cw[c_b_memread];
      r_exmem_memwrite <= r_idex_cw[c_b_memwrite];
      r_exmem_regwrite <= r_idex_cw[c_b_regwrite];
      r_exmem_memtoreg <= r_idex_cw[c_b_memtoreg];
      r_memwb_regwrite <= r_exmem_regwrite;
      r_memwb_memtoreg <= r_exmem_memtoreg;
      if (w_illegal_op) r_illegal <= 1'b1;
    end
  end

  assign ExRt_o      = r_idex_rt;
  assign ALUSrc_o    = r_idex_cw[c_b_alusrc];
  assign ALUOp_o     = r_idex_cw[ALUOP_W:1];
  assign RegDst_o    = r_idex_cw[c_b_regdst];
  assign MemRead_o   = r_exmem_memread;
  assign MemWrite_o  = r_exmem_memwrite;
  assign RegWrite_o  = r_memwb_regwrite;
  assign MemtoReg_o  = r_memwb_memtoreg;
  assign IllegalOp_o = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_pipe_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_control
// Purpose  : Directed plus random stimulus for pipe_control against an
//            instruction-level pipeline model.
// Revision : 1.0
// ============================================================================
module tb_pipe_control;

  localparam logic [5:0] c_rtype = 6'b000000;
  localparam logic [5:0] c_addi  = 6'b001000;
  localparam logic [5:0] c_lw    = 6'b100011;
  localparam logic [5:0] c_sw    = 6'b101011;
  localparam logic [5:0] c_beq   = 6'b000100;
  localparam logic [5:0] c_j     = 6'b000010;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] Op_i = '0;
  logic [4:0] RsAddr_i = '0;
  logic [4:0] RtAddr_i = '0;
  logic       Eq_i = 1'b0;
  logic       Hold_i = 1'b0;
  logic       PCWrite_o, IFIDWrite_o, IFFlush_o, Branch_o, Jump_o;
  logic [7:0] Ctrl_o;
  logic [4:0] ExRt_o;
  logic       ALUSrc_o;
  logic [1:0] ALUOp_o;
  logic       RegDst_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o, IllegalOp_o;

  pipe_control dut (
    .clk_i(clk_i), .rst_i(rst_i), .Op_i(Op_i), .RsAddr_i(RsAddr_i),
    .RtAddr_i(RtAddr_i), .Eq_i(Eq_i), .Hold_i(Hold_i),
    .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o), .IFFlush_o(IFFlush_o),
    .Branch_o(Branch_o), .Jump_o(Jump_o), .Ctrl_o(Ctrl_o), .ExRt_o(ExRt_o),
    .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o), .RegDst_o(RegDst_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o),
    .MemtoReg_o(MemtoReg_o), .IllegalOp_o(IllegalOp_o)
  );

  always #5 clk_i = ~clk_i;

  // One in-flight instruction's control fields; index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct packed {
    logic       memtoreg;
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       regdst;
    logic [1:0] aluop;
    logic       alusrc;
    logic [4:0] rt;
  } tok_t;

  tok_t m_pipe [3];
  logic m_illegal;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic tok_t decode(input logic [5:0] op, input logic [4:0] rt);
    tok_t t = '0;
    t.rt = rt;
    case (op)
      c_rtype: begin t.aluop = 2'b11; t.regdst = 1'b1; t.regwrite = 1'b1; end
      c_addi:  begin t.alusrc = 1'b1; t.regwrite = 1'b1; end
      c_lw:    begin t.alusrc = 1'b1; t.memread = 1'b1; t.regwrite = 1'b1; t.memtoreg = 1'b1; end
      c_sw:    begin t.alusrc = 1'b1; t.memwrite = 1'b1; end
      c_beq:   t.aluop = 2'b01;
      default: ;
    endcase
    return t;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {c_rtype, c_addi, c_lw, c_sw, c_beq, c_j};
  endfunction

  task automatic cycle(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic eq, input logic hold);
    bit   st, run, br, jp;
    tok_t d;
    @(negedge clk_i);
    Op_i = op; RsAddr_i = rs; RtAddr_i = rt; Eq_i = eq; Hold_i = hold;
    #1;
    st  = m_pipe[0].memread && (m_pipe[0].rt != 0) &&
          (m_pipe[0].rt == rs || m_pipe[0].rt == rt);
    run = !hold;
    br  = run && (op == c_beq) && eq && !st;
    jp  = run && (op == c_j) && !st;
    d   = decode(op, rt);
    check("pc_ifid", 32'({PCWrite_o, IFIDWrite_o}), 32'({2{run && !st}}));
    check("redirect", 32'({IFFlush_o, Branch_o, Jump_o}), 32'({br | jp, br, jp}));
    check("ctrl", 32'(Ctrl_o), 32'({d.memtoreg, d.regwrite, d.memwrite, d.memread,
                                    d.regdst, d.aluop, d.alusrc}));
    check("ex_stage", 32'({ExRt_o, ALUSrc_o, ALUOp_o, RegDst_o}),
          32'({m_pipe[0].rt, m_pipe[0].alusrc, m_pipe[0].aluop, m_pipe[0].regdst}));
    check("mem_stage", 32'({MemRead_o, MemWrite_o}),
          32'({m_pipe[1].memread, m_pipe[1].memwrite}));
    check("wb_stage", 32'({RegWrite_o, MemtoReg_o}),
          32'({m_pipe[2].regwrite, m_pipe[2].memtoreg}));
    check("illegal", 32'(IllegalOp_o), 32'(m_illegal));
    @(posedge clk_i);
    if (!hold) begin
      if (!is_legal(op)) m_illegal = 1'b1;
      m_pipe[2] = m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = st ? '0 : d;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    check("rst_async", 32'({PCWrite_o, IFIDWrite_o, IFFlush_o, Branch_o, Jump_o, ExRt_o,
                            ALUSrc_o, ALUOp_o, RegDst_o, MemRead_o, MemWrite_o,
                            RegWrite_o, MemtoReg_o, IllegalOp_o}), 32'd0);
    for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    m_illegal = 1'b0;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
  endtask

  initial begin
    logic [5:0] op;
    int         sel;
    for (int i = 0; i < 3; i++) m_pipe[i] = '0;
    m_illegal = 1'b0;
    do_reset();

    // R-type flowing through, then load-use hazard and its resolution
    cycle(c_rtype, 5'd1, 5'd2, 1'b0, 1'b0);
    repeat (3) cycle(c_addi, 5'd0, 5'd0, 1'b0, 1'b0);
    cycle(c_lw, 5'd1, 5'd8, 1'b0, 1'b0);
    cycle(c_rtype, 5'd8, 5'd3, 1'b0, 1'b0);
    cycle(c_rtype, 5'd8, 5'd3, 1'b0, 1'b0);
    cycle(c_lw, 5'd1, 5'd0, 1'b0, 1'b0);
    cycle(c_rtype, 5'd0, 5'd5, 1'b0, 1'b0);
    // Branches: taken, not taken, and suppressed by a stall
    cycle(c_beq, 5'd1, 5'd1, 1'b1, 1'b0);
    cycle(c_beq, 5'd1, 5'd2, 1'b0, 1'b0);
    cycle(c_lw, 5'd2, 5'd4, 1'b0, 1'b0);
    cycle(c_beq, 5'd4, 5'd4, 1'b1, 1'b0);
    cycle(c_beq, 5'd4, 5'd4, 1'b1, 1'b0);
    // Jump under hold, then released
    cycle(c_lw, 5'd1, 5'd9, 1'b0, 1'b0);
    repeat (2) cycle(c_j, 5'd0, 5'd0, 1'b0, 1'b1);
    cycle(c_j, 5'd0, 5'd0, 1'b0, 1'b0);
    // Undefined opcode is sticky until reset
    cycle(6'b111111, 5'd0, 5'd0, 1'b0, 1'b0);
    repeat (2) cycle(c_lw, 5'd3, 5'd6, 1'b0, 1'b0);
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      sel = int'($urandom_range(0, 13));
      case (sel)
        0, 1:       op = c_rtype;
        2:          op = c_addi;
        3, 4, 5:    op = c_lw;
        6:          op = c_sw;
        7, 8:       op = c_beq;
        9:          op = c_j;
        default:    op = 6'($urandom);
      endcase
      cycle(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
